// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        MAC,
        DRAIN
    } state_t;

    localparam int unsigned WD_IN  = 24;
    localparam int unsigned WD_OUT = 24;

    // (a - b) mod n for a, b < n, without relying on power-of-two wrap.
    function automatic int unsigned wrap_sub(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        return (a >= b) ? (a - b) : (a + n - b);
    endfunction

endpackage

// File: rtl/fir_addr_ctr.sv
// Up-counter with terminal-count flag; the owner clears it on wrap to make it mod-N.
module fir_addr_ctr #(
    parameter int unsigned N  = 64,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] count,
    output logic          wrap
);

    assign wrap = (count == AW'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequencer for a shared-MAC FIR: delay-line write, tap address stepping,
// accumulator enable/clear alignment and completion pulse.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned N_TAPS = 64,
    parameter int unsigned PIPE   = 2,
    parameter int unsigned AW     = $clog2(N_TAPS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          zero_sel,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] coef_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          acc_done,
    output logic          busy
);

    localparam int unsigned DW = (PIPE > 0) ? $clog2(PIPE + 1) : 1;

    state_t          state;
    logic            init_go;
    logic [DW-1:0]   drain_cnt;
    logic            drain_last;

    logic [AW-1:0]   tap;
    logic            tap_wrap;
    logic            tap_en;
    logic [AW-1:0]   ptr;
    logic            ptr_wrap;

    logic            issue;
    logic            first;

    // init_go holds off the clearing sweep for the cycle after a reset edge,
    // so every strobe is low while reset is being applied.
    assign tap_en     = ((state == INIT) && init_go) || (state == MAC);
    assign drain_last = (state == DRAIN) && (drain_cnt == DW'(PIPE));

    fir_addr_ctr #(
        .N  (N_TAPS),
        .AW (AW)
    ) u_tap_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tap_en),
        .clr     (tap_en && tap_wrap),
        .count   (tap),
        .wrap    (tap_wrap)
    );

    fir_addr_ctr #(
        .N  (N_TAPS),
        .AW (AW)
    ) u_ptr_ctr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (drain_last),
        .clr     (drain_last && ptr_wrap),
        .count   (ptr),
        .wrap    (ptr_wrap)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT;
            init_go   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_go <= 1'b1;
                    if (init_go && tap_wrap) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        state <= MAC;
                    end
                end
                MAC: begin
                    if (tap_wrap) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign zero_sel  = (state == INIT) && init_go;
    assign wr_en     = zero_sel || ((state == IDLE) && in_valid);
    assign wr_addr   = (state == INIT) ? tap : ptr;
    assign coef_addr = tap;
    assign rd_addr   = AW'(wrap_sub(32'(ptr), 32'(tap), N_TAPS));
    assign acc_done  = drain_last;

    assign issue = (state == MAC);
    assign first = issue && (tap == '0);

    // Issue/first flags ride a PIPE-deep delay so they meet the product at the accumulator.
    if (PIPE == 0) begin : g_nopipe
        assign acc_en  = issue;
        assign acc_clr = first;
    end else begin : g_pipe
        logic [PIPE-1:0] en_sr;
        logic [PIPE-1:0] clr_sr;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                en_sr  <= '0;
                clr_sr <= '0;
            end else begin
                en_sr[0]  <= issue;
                clr_sr[0] <= first;
                for (int unsigned i = 1; i < PIPE; i++) begin
                    en_sr[i]  <= en_sr[i-1];
                    clr_sr[i] <= clr_sr[i-1];
                end
            end
        end

        assign acc_en  = en_sr[PIPE-1];
        assign acc_clr = clr_sr[PIPE-1];
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (N_TAPS=4, PIPE=2) with a small MAC/RAM/ROM loop.
module tb_fir_mac_sequencer;

    localparam int unsigned N_TAPS = 4;
    localparam int unsigned PIPE   = 2;
    localparam int unsigned AW     = 2;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          zero_sel;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] coef_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          acc_done;
    logic          busy;

    logic [23:0]   data_in;
    logic [23:0]   ram [N_TAPS];
    logic [31:0]   coef [N_TAPS];
    logic [31:0]   p1, p2, acc, y_lat;

    int n_tests;
    int n_fail;

    fir_mac_sequencer #(
        .N_TAPS (N_TAPS),
        .PIPE   (PIPE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .zero_sel  (zero_sel),
        .rd_addr   (rd_addr),
        .coef_addr (coef_addr),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .acc_done  (acc_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: sync RAM/ROM read + registered multiply = 2 cycles to the accumulator.
    initial begin
        coef[0] = 32'd1;
        coef[1] = 32'd2;
        coef[2] = 32'd3;
        coef[3] = 32'd4;
    end

    always @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= zero_sel ? 24'd0 : data_in;
        p1 <= 32'(ram[rd_addr]) * coef[coef_addr];
        p2 <= p1;
        if (acc_en) acc <= acc_clr ? p2 : acc + p2;
        if (acc_done) y_lat <= acc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accept one sample and follow it through MAC/DRAIN; rd_pk lists rd_addr for k=0..3.
    task automatic do_sample(input logic [23:0] d, input logic [1:0] ptr,
                             input logic [7:0] rd_pk, input logic [31:0] exp_y,
                             input bit chk_y);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = d;
        #1;
        check("accept in_ready", 32'(in_ready), 32'd1);
        check("accept wr_en", 32'(wr_en), 32'd1);
        check("accept zero_sel", 32'(zero_sel), 32'd0);
        check("accept wr_addr", 32'(wr_addr), 32'(ptr));
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (c <= 4) begin
                check($sformatf("rd_addr c%0d", c), 32'(rd_addr), 32'(rd_pk[(4-c)*2 +: 2]));
                check($sformatf("coef_addr c%0d", c), 32'(coef_addr), 32'(c - 1));
            end
            check($sformatf("acc_en c%0d", c), 32'(acc_en), 32'(c >= 3 && c <= 6));
            check($sformatf("acc_clr c%0d", c), 32'(acc_clr), 32'(c == 3));
            check($sformatf("acc_done c%0d", c), 32'(acc_done), 32'(c == 7));
            check($sformatf("in_ready c%0d", c), 32'(in_ready), 32'(c == 8));
            if (c == 8 && chk_y) check("y_out", y_lat, exp_y);
        end
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s wr_en %0d", tag, i), 32'(wr_en), 32'd1);
            check($sformatf("%s zero_sel %0d", tag, i), 32'(zero_sel), 32'd1);
            check($sformatf("%s wr_addr %0d", tag, i), 32'(wr_addr), 32'(i));
            check($sformatf("%s in_ready %0d", tag, i), 32'(in_ready), 32'd0);
            check($sformatf("%s acc_done %0d", tag, i), 32'(acc_done), 32'd0);
            check($sformatf("%s acc_en %0d", tag, i), 32'(acc_en), 32'd0);
        end
        @(negedge clk);
        #1;
        check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
        check({tag, " idle wr_en"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev_acc;
        int last_acc;
        int n_acc;
        int n_done;

        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;

        // Reset held: everything quiet, busy in INIT.
        repeat (3) @(negedge clk);
        #1;
        check("rst wr_en", 32'(wr_en), 32'd0);
        check("rst acc_en", 32'(acc_en), 32'd0);
        check("rst acc_done", 32'(acc_done), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        check_sweep("init");

        // Impulse through coefs 1,2,3,4; write pointer walks 0,1,2,3 then wraps to 0.
        do_sample(24'd1, 2'd0, 8'b00_11_10_01, 32'd1, 1'b1);
        do_sample(24'd0, 2'd1, 8'b01_00_11_10, 32'd2, 1'b1);
        do_sample(24'd0, 2'd2, 8'b10_01_00_11, 32'd3, 1'b1);
        do_sample(24'd0, 2'd3, 8'b11_10_01_00, 32'd4, 1'b1);
        do_sample(24'd0, 2'd0, 8'b00_11_10_01, 32'd0, 1'b1);

        // in_valid held high: one acceptance per 8 cycles, one acc_done 7 cycles after each.
        prev_acc = -1;
        last_acc = -1;
        n_acc    = 0;
        n_done   = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (in_valid && in_ready) begin
                if (prev_acc >= 0) check("accept gap", 32'(cyc - prev_acc), 32'd8);
                prev_acc = cyc;
                last_acc = cyc;
                n_acc++;
            end
            if (acc_done) begin
                check("done latency", 32'(cyc - last_acc), 32'd7);
                n_done++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream accepts", 32'(n_acc), 32'd5);
        check("stream dones", 32'(n_done), 32'd5);

        // Reset pulse during MAC k=2 abandons the sample and restarts the clear sweep.
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 24'd5;
        #1;
        check("abort accept", 32'(wr_en), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort k", 32'(coef_addr), 32'd2);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post-rst wr_en", 32'(wr_en), 32'd0);
        check("post-rst zero_sel", 32'(zero_sel), 32'd0);
        check("post-rst acc_en", 32'(acc_en), 32'd0);
        check("post-rst acc_clr", 32'(acc_clr), 32'd0);
        check("post-rst acc_done", 32'(acc_done), 32'd0);
        check("post-rst in_ready", 32'(in_ready), 32'd0);
        check("post-rst busy", 32'(busy), 32'd1);
        check_sweep("reinit");
        do_sample(24'd7, 2'd0, 8'b00_11_10_01, 32'd7, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
